// File: rtl/video_raster_sink_if.sv
// Pull-stream link between the pixel source (master) and the raster sink (slave):
// the sink raises VideoReady and the source must present a valid word on video.
interface video_raster_sink_if;
   logic [23:0] video;
   logic        VideoReady;

   modport master (output video, input  VideoReady);
   modport slave  (input  video, output VideoReady);
endinterface

// File: rtl/video_raster_sink.sv
// Raster-timing video sink: pulls one pixel per active position and drives registered
// rgb/de/hsync/vsync/frame_start. Define RASTER_BORDER_EN to force a white frame border.
module video_raster_sink #(
   parameter int H_ACTIVE        = 640,
   parameter int H_FP            = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BP            = 48,
   parameter int V_ACTIVE        = 480,
   parameter int V_FP            = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BP            = 33,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      Enable,
   video_raster_sink_if.slave        vid,
   output logic [23:0]               rgb,
   output logic                      de,
   output logic                      hsync,
   output logic                      vsync,
   output logic                      frame_start
);

   localparam logic [11:0] HA         = 12'(H_ACTIVE);
   localparam logic [11:0] VA         = 12'(V_ACTIVE);
   localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [11:0] HS_FIRST   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [11:0] VS_FIRST   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic        SYNC_ON    = (SYNC_ACTIVE_LOW == 0);
   localparam logic        SYNC_OFF   = ~SYNC_ON;

   localparam logic [1:0]  IDLE  = 2'd0;
   localparam logic [1:0]  RUN   = 2'd1;
   localparam logic [1:0]  DRAIN = 2'd2;

   logic [1:0]  state, state_nxt;
   logic [11:0] hcnt, vcnt;
   logic        running, line_end, frame_end, in_active, hs_act, vs_act;
   logic [23:0] pixel;

   assign running   = (state != IDLE);
   assign line_end  = (hcnt == H_LAST);
   assign frame_end = line_end && (vcnt == V_LAST);
   assign in_active = running && (hcnt < HA) && (vcnt < VA);
   assign hs_act    = running && (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
   assign vs_act    = running && (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);

   // Gated by Reset so the source is never asked for a word on a cycle that resets.
   assign vid.VideoReady = in_active && !Reset;

`ifdef RASTER_BORDER_EN
   logic border;
   assign border = (hcnt == 12'd0) || (hcnt == HA - 12'd1) ||
                   (vcnt == 12'd0) || (vcnt == VA - 12'd1);
   assign pixel  = border ? 24'hFFFFFF : vid.video;
`else
   assign pixel  = vid.video;
`endif

   always_comb begin
      // NOTE: default assignment first, so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE:    if (Enable) state_nxt = RUN;
         RUN:     if (!Enable) state_nxt = DRAIN;
         DRAIN: begin
            if (Enable)         state_nxt = RUN;
            else if (frame_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (Reset) begin
         state       <= IDLE;
         hcnt        <= 12'd0;
         vcnt        <= 12'd0;
         rgb         <= 24'h000000;
         de          <= 1'b0;
         hsync       <= SYNC_OFF;
         vsync       <= SYNC_OFF;
         frame_start <= 1'b0;
      end else begin
         state <= state_nxt;
         if (!running) begin
            hcnt <= 12'd0;
            vcnt <= 12'd0;
         end else if (line_end) begin
            hcnt <= 12'd0;
            vcnt <= frame_end ? 12'd0 : vcnt + 12'd1;
         end else begin
            hcnt <= hcnt + 12'd1;
         end

         rgb         <= in_active ? pixel : 24'h000000;
         de          <= in_active;
         hsync       <= hs_act ? SYNC_ON : SYNC_OFF;
         vsync       <= vs_act ? SYNC_ON : SYNC_OFF;
         frame_start <= running && (hcnt == 12'd0) && (vcnt == 12'd0);
      end
   end

endmodule

// File: tb/tb_video_raster_sink.sv
// Scoreboard bench for video_raster_sink on a 14x7 raster (8x4 active, active-low syncs).
// Build with +define+RASTER_BORDER_EN to check the border override as well.
module tb_video_raster_sink;

   localparam int HT = 14;
   localparam int VT = 7;
   localparam int FRAME = HT * VT;

   logic        Clock, Reset, Enable;
   logic [23:0] rgb;
   logic        de, hsync, vsync, frame_start;

   video_raster_sink_if vif ();

   video_raster_sink #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_ACTIVE_LOW(1)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Enable      (Enable),
      .vid         (vif),
      .rgb         (rgb),
      .de          (de),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_start (frame_start)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int pulls  = 0;
   bit sync_chk = 1'b0;
   logic [23:0] exp_q[$];

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [23:0] pat(input int n);
      logic [7:0] b;
      b = n[7:0];
      return {8'h1A ^ b, 8'hBC, 8'h9C + b};
   endfunction

   // Source: serve a fresh word after each pull; queue the expected encoder output.
   initial begin
      int  word_n  = 0;
      int  pix_idx = 0;
      bit  adv;
      logic [23:0] e;
      vif.video = pat(0);
      forever begin
         @(negedge Clock);
         if (Reset) pix_idx = 0;
         adv = 1'b0;
         if (vif.VideoReady) begin
            e = vif.video;
`ifdef RASTER_BORDER_EN
            if ((pix_idx % 8) == 0 || (pix_idx % 8) == 7 ||
                ((pix_idx / 8) % 4) == 0 || ((pix_idx / 8) % 4) == 3)
               e = 24'hFFFFFF;
`endif
            exp_q.push_back(e);
            pulls++;
            pix_idx++;
            adv = 1'b1;
         end
         @(posedge Clock);
         #1;
         if (adv) begin
            word_n++;
            vif.video = pat(word_n);
         end
      end
   end

   // Monitor: scoreboard pops on de, plus raster-position checks anchored on frame_start.
   initial begin
      int  pos = 0;
      bit  anchored = 1'b0;
      bit  have_fs  = 1'b0;
      int  last_fs = 0;
      int  pops = 0;
      int  last_pops = 0;
      int  h, v;
      logic [23:0] e;
      forever begin
         @(negedge Clock);
         if (Reset) begin
            anchored = 1'b0;
            have_fs  = 1'b0;
         end else if (frame_start) begin
            if (sync_chk && have_fs) begin
               check("frame_period", cyc - last_fs, FRAME);
               check("pixels_per_frame", pops - last_pops, 32);
            end
            last_fs   = cyc;
            last_pops = pops;
            have_fs   = 1'b1;
            anchored  = 1'b1;
            pos       = 0;
         end else if (anchored) begin
            pos = (pos == FRAME - 1) ? 0 : pos + 1;
         end

         if (sync_chk && anchored && !Reset) begin
            h = pos % HT;
            v = pos / HT;
            check("de_at_pos",    de,    (h < 8) && (v < 4));
            check("hsync_at_pos", hsync, !((h >= 10) && (h <= 11)));
            check("vsync_at_pos", vsync, !(v == 5));
         end

         if (de) begin
            check("sb_has_entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("rgb_pixel", rgb, e);
               pops++;
            end
         end else begin
            check("rgb_blank", rgb, 24'h0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic wait_fs();
      bit seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge Clock);
         if (frame_start) seen = 1'b1;
      end
      check("frame_start_seen", seen, 1);
   endtask

   task automatic check_idle(input string tag);
      @(negedge Clock);
      check({tag, "_ready"}, vif.VideoReady, 0);
      check({tag, "_de"},    de,    0);
      check({tag, "_hsync"}, hsync, 1);
      check({tag, "_vsync"}, vsync, 1);
      check({tag, "_fs"},    frame_start, 0);
   endtask

   initial begin
      int p0;
      Reset  = 1'b1;
      Enable = 1'b0;

      // Reset for three cycles, then idle with Enable low.
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b0;
      for (int i = 0; i < 12; i++) check_idle("idle");
      check("idle_pulls", pulls, 0);

      // Continuous run: two full frames of sync/de/pixel checks.
      @(posedge Clock); #1 Enable = 1'b1;
      wait_fs();
      @(posedge Clock); #1 sync_chk = 1'b1;
      repeat (2 * FRAME + 5) @(posedge Clock);
      #1 sync_chk = 1'b0;
      Enable = 1'b0;
      repeat (250) @(posedge Clock);
      check_idle("after_run");
      p0 = pulls;

      // Drop Enable at (3,1): the frame completes, then no more pulls.
      @(posedge Clock); #1 Enable = 1'b1;
      wait_fs();
      repeat (16) @(posedge Clock);
      #1 Enable = 1'b0;
      repeat (150) @(posedge Clock);
      #1 check("drain_pulls", pulls - p0, 32);
      for (int i = 0; i < 20; i++) check_idle("drained");
      check("drained_no_pull", pulls - p0, 32);

      // Drop at (3,1), re-enable at (2,3): next frame follows with no gap.
      p0 = pulls;
      @(posedge Clock); #1 Enable = 1'b1;
      wait_fs();
      repeat (16) @(posedge Clock);
      #1 Enable = 1'b0;
      repeat (27) @(posedge Clock);
      #1 Enable = 1'b1;
      sync_chk = 1'b1;
      wait_fs();
      @(posedge Clock); #1 sync_chk = 1'b0;
      Enable = 1'b0;
      repeat (150) @(posedge Clock);
      #1 check("reenable_pulls", pulls - p0, 64);
      check_idle("reenable_idle");

      // Reset at (5,2) with Enable held high.
      p0 = pulls;
      @(posedge Clock); #1 Enable = 1'b1;
      wait_fs();
      repeat (32) @(posedge Clock);
      #1 Reset = 1'b1;
      #1 check("reset_ready_now", vif.VideoReady, 0);
      @(posedge Clock);
      check_idle("reset");
      check("reset_rgb", rgb, 24'h0);
      check("pulls_before_reset", pulls - p0, 21);
      p0 = pulls;
      @(posedge Clock); #1 Reset = 1'b0;
      @(negedge Clock);
      check("restart_ready_idle", vif.VideoReady, 0);
      @(negedge Clock);
      check("restart_first_pull", vif.VideoReady, 1);
      check("restart_fs_early", frame_start, 0);
      @(negedge Clock);
      check("restart_fs", frame_start, 1);
      check("restart_de", de, 1);
      @(posedge Clock); #1 Enable = 1'b0;
      repeat (150) @(posedge Clock);
      #1 check("restart_frame_pulls", pulls - p0, 32);
      check_idle("final_idle");

      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
